imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage; successor to the combinational immediate-extension unit.
- XLEN-generic (32/64); adds CSR-uimm and shift-amount formats.
- Optionally derives the format from the opcode itself.
- Sits between fetch and decode behind a valid/ready handshake with an internal skid buffer, so backpressure from decode never drops or reorders instructions.

---
 rtl/imm_gen_pipe_pkg.sv | 31 +++
 rtl/imm_gen_pipe_format_decode.sv | 67 ++++++
 rtl/imm_gen_pipe.sv | 76 +++++++
 tb/tb_imm_gen_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: immediate formats, opcodes and buffer entry type shared by the immediate generator
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_Z, FMT_SH, FMT_NONE
    } imm_fmt_e;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Sized for the widest supported XLEN and tag; narrower builds use the low bits.
    typedef struct packed {
        logic [63:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
        logic [63:0] tag;
    } entry_t;

endpackage

// File: rtl/imm_gen_pipe_format_decode.sv
// imm_format_decode: combinational instruction -> immediate format, illegal flag and extended immediate
module imm_format_decode import imm_pkg::*; #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output imm_fmt_e        fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [6:0] op;
    logic [2:0] f3;
    logic s, shift, sh5, auto_ill;
    imm_fmt_e auto_fmt;
    logic [63:0] imm64;

    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign s     = instr[31];
    assign shift = f3 == 3'b001 || f3 == 3'b101;

    // opcode/funct3 to format; word shifts on RV64 keep a 5-bit shamt
    always_comb begin
        auto_fmt = FMT_NONE;
        auto_ill = 1'b0;
        sh5      = 1'b0;
        case (op)
            OP_IMM:            auto_fmt = shift ? FMT_SH : FMT_I;
            OP_IMM32: begin
                auto_fmt = (XLEN == 64) ? (shift ? FMT_SH : FMT_I) : FMT_NONE;
                auto_ill = XLEN != 64;
                sh5      = 1'b1;
            end
            OP_LOAD, OP_JALR:  auto_fmt = FMT_I;
            OP_STORE:          auto_fmt = FMT_S;
            OP_BRANCH:         auto_fmt = FMT_B;
            OP_JAL:            auto_fmt = FMT_J;
            OP_LUI, OP_AUIPC:  auto_fmt = FMT_U;
            OP_SYSTEM:         auto_fmt = f3[2] ? FMT_Z : FMT_I;
            OP_OP:             auto_ill = 1'b0;
            OP_OP32:           auto_ill = XLEN != 64;
            default:           auto_ill = 1'b1;
        endcase
    end

    assign fmt     = AUTO_DECODE ? auto_fmt : imm_fmt_e'(imm_src);
    assign illegal = AUTO_DECODE ? auto_ill : 1'b0;

    // build at 64 bits; truncation to 32 leaves the correct RV32 value
    always_comb begin
        case (fmt)
            FMT_I:   imm64 = {{52{s}}, instr[31:20]};
            FMT_S:   imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            FMT_B:   imm64 = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm64 = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   imm64 = {{32{s}}, instr[31:12], 12'b0};
            FMT_Z:   imm64 = {59'b0, instr[19:15]};
            FMT_SH:  imm64 = (XLEN == 64 && !(AUTO_DECODE && sh5)) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            default: imm64 = 64'b0;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and optional two-entry skid buffer
module imm_gen_pipe import imm_pkg::*; #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1,
    parameter bit SKID        = 1,
    parameter int TAG_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    occ_e state, state_nxt;
    entry_t head, tail, fresh;
    logic ready_q, accept, drain, dec_ill;
    imm_fmt_e dec_fmt;
    logic [XLEN-1:0] dec_imm;

    imm_format_decode #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_dec (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .fmt     (dec_fmt),
        .illegal (dec_ill),
        .imm     (dec_imm)
    );

    assign fresh       = '{imm: 64'(dec_imm), fmt: dec_fmt, illegal: dec_ill, tag: 64'(in_tag)};
    assign out_valid   = state != EMPTY;
    assign in_ready    = SKID ? ready_q : (state == EMPTY || out_ready);
    assign accept      = in_valid && in_ready && !flush;
    assign drain       = out_valid && out_ready;
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_tag     = head.tag[TAG_W-1:0];

    // occupancy transitions; without the skid buffer accepting in ONE implies a drain, so TWO is unreachable
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = accept ? ONE : EMPTY;
            ONE:     state_nxt = (accept && !drain) ? TWO : (drain && !accept) ? EMPTY : ONE;
            TWO:     state_nxt = drain ? ONE : TWO;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // head is always the oldest entry; tail only fills when head is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            head    <= '0;
            tail    <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= state_nxt != TWO;
            if (accept && (state == EMPTY || (state == ONE && drain))) head <= fresh;
            else if (drain && state == TWO) head <= tail;
            if (accept && state == ONE && !drain) tail <= fresh;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving RV32 and RV64 instances with the same instruction stream
module tb_imm_gen_pipe;
    import imm_pkg::*;

    typedef struct {
        logic [63:0] i64;
        logic [31:0] i32;
        logic [2:0]  f64, f32;
        logic        il64, il32;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;
    logic [2:0] in_imm_src;
    logic rdy32, rdy64, v32, v64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0] fmt32, fmt64;

    exp_t q[$];
    exp_t cur;
    exp_t v_exp[12];
    logic [31:0] v_ins[12];
    logic [31:0] tag_ctr = 32'h100;
    int pass_n = 0;
    int total = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .SKID(1), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(v32),
        .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .SKID(1), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(v64),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [63:0] i64, input logic [31:0] i32, input logic [2:0] f64,
                                input logic [2:0] f32, input logic il64, input logic il32);
        mk = '{i64: i64, i32: i32, f64: f64, f32: f32, il64: il64, il32: il32, tag: 32'h0};
    endfunction

    // monitor: compare the head of the scoreboard whenever an output is presented, pop on transfer
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (v64 || v32) begin
                if (q.size() == 0) chk("spurious_valid", {62'b0, v32, v64}, 64'd0);
                else begin
                    chk("valid32", {63'b0, v32}, 64'd1);
                    chk("imm64", imm64, q[0].i64);
                    chk("imm32", {32'b0, imm32}, {32'b0, q[0].i32});
                    chk("fmt64", {61'b0, fmt64}, {61'b0, q[0].f64});
                    chk("fmt32", {61'b0, fmt32}, {61'b0, q[0].f32});
                    chk("ill64", {63'b0, ill64}, {63'b0, q[0].il64});
                    chk("ill32", {63'b0, ill32}, {63'b0, q[0].il32});
                    chk("tag64", {32'b0, tag64}, {32'b0, q[0].tag});
                    chk("tag32", {32'b0, tag32}, {32'b0, q[0].tag});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && rdy64 && !flush) q.push_back(cur);
            if (flush) q.delete();
        end
    end

    task automatic present(input int idx);
        cur = v_exp[idx];
        cur.tag = tag_ctr;
        in_instr = v_ins[idx];
        in_tag = tag_ctr;
        in_valid = 1'b1;
        tag_ctr++;
    endtask

    task automatic send(input int idx);
        logic acc;
        acc = 1'b0;
        present(idx);
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = rdy64;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || v64) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        v_ins = '{32'hFFF00093, 32'hFE000EE3, 32'h800002B7, 32'h03F09093, 32'h300FD073, 32'h0000007F,
                  32'h003100B3, 32'hFE112E23, 32'h0080006F, 32'h12345017, 32'h03F0101B, 32'h003100BB};
        v_exp[0]  = mk(64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd0, 3'd0, 1'b0, 1'b0);
        v_exp[1]  = mk(64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
        v_exp[2]  = mk(64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 3'd4, 1'b0, 1'b0);
        v_exp[3]  = mk(64'h000000000000003F, 32'h0000001F, 3'd6, 3'd6, 1'b0, 1'b0);
        v_exp[4]  = mk(64'h000000000000001F, 32'h0000001F, 3'd5, 3'd5, 1'b0, 1'b0);
        v_exp[5]  = mk(64'h0000000000000000, 32'h00000000, 3'd7, 3'd7, 1'b1, 1'b1);
        v_exp[6]  = mk(64'h0000000000000000, 32'h00000000, 3'd7, 3'd7, 1'b0, 1'b0);
        v_exp[7]  = mk(64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd1, 3'd1, 1'b0, 1'b0);
        v_exp[8]  = mk(64'h0000000000000008, 32'h00000008, 3'd3, 3'd3, 1'b0, 1'b0);
        v_exp[9]  = mk(64'h0000000012345000, 32'h12345000, 3'd4, 3'd4, 1'b0, 1'b0);
        v_exp[10] = mk(64'h000000000000001F, 32'h00000000, 3'd6, 3'd7, 1'b0, 1'b1);
        v_exp[11] = mk(64'h0000000000000000, 32'h00000000, 3'd7, 3'd7, 1'b0, 1'b1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_tag = 32'h0; in_imm_src = 3'd0; cur = v_exp[0];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {62'b0, v32, v64}, 64'd0);
        chk("rst_ready", {62'b0, rdy32, rdy64}, 64'd3);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_fmt_ill_tag", {28'b0, fmt64, ill64, tag64}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0);
        chk("latency", {63'b0, v64}, 64'd1);
        for (int i = 1; i < 12; i++) send(i);
        drain();

        out_ready = 1'b0;
        send(0);
        send(1);
        chk("ready_after_b", {63'b0, rdy64}, 64'd0);
        present(2);
        tag_ctr--;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("c_stalled", {62'b0, rdy32, rdy64}, 64'd0);
        end
        out_ready = 1'b1;
        send(2);
        drain();

        out_ready = 1'b0;
        send(3);
        send(4);
        present(5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {62'b0, v32, v64}, 64'd0);
        chk("flush_ready", {62'b0, rdy32, rdy64}, 64'd3);
        out_ready = 1'b1;
        send(6);
        drain();

        out_ready = 1'b0;
        send(7);
        send(8);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {62'b0, v32, v64}, 64'd0);
        chk("arst_ready", {62'b0, rdy32, rdy64}, 64'd3);
        chk("arst_imm", imm64 | {32'b0, imm32}, 64'd0);
        chk("arst_tag", {tag32, tag64}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(9);
        chk("latency_after_rst", {62'b0, v32, v64}, 64'd3);
        drain();

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end

endmodule
